// File: rtl/pad_cfg_loader.sv
// Serial config-chain loader: fetches one CFG_W word per pad (highest index first)
// and shifts it MSB-first onto ser_data_o/ser_clk_o, then strobes ser_load_o.
module pad_cfg_loader #(
    parameter int NUM_PADS = 8,
    parameter int CFG_W    = 13,
    parameter int CLK_DIV  = 2,
    localparam int AW      = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [AW-1:0]    cfg_rd_addr_o,
    input  logic [CFG_W-1:0] cfg_rd_data_i,
    output logic             ser_clk_o,
    output logic             ser_data_o,
    output logic             ser_load_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (CFG_W > 1) ? $clog2(CFG_W) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [AW-1:0]    addr_d;
    logic [CFG_W-1:0] sreg_q, sreg_d;
    logic             ovr_d;
    logic             div_last;

    assign div_last = (div_q == DW'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        addr_d  = cfg_rd_addr_o;
        sreg_d  = sreg_q;
        ovr_d   = overrun_o;
        unique case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = FETCH;
                    addr_d  = AW'(NUM_PADS - 1);
                    ovr_d   = 1'b0;
                end
            end
            FETCH: begin
                sreg_d  = cfg_rd_data_i;
                bit_d   = BW'(CFG_W - 1);
                div_d   = '0;
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                div_d = div_q + DW'(1);
                if (div_last) begin
                    div_d   = '0;
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                div_d = div_q + DW'(1);
                if (div_last) begin
                    div_d  = '0;
                    sreg_d = sreg_q << 1;
                    if (bit_q != '0) begin
                        bit_d   = bit_q - BW'(1);
                        state_d = SHIFT_LO;
                    end else if (cfg_rd_addr_o != '0) begin
                        addr_d  = cfg_rd_addr_o - AW'(1);
                        state_d = FETCH;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                div_d = div_q + DW'(1);
                if (div_last) begin
                    div_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && start_i) ovr_d = 1'b1;
        // DONE is already committed, so a late abort cannot suppress its pulse
        if (state_q != IDLE && state_q != DONE && abort_i) begin
            state_d = IDLE;
            div_d   = '0;
        end
    end

    // Outputs are registered off the next state so they line up with state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            sreg_q        <= '0;
            cfg_rd_addr_o <= '0;
            overrun_o     <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            ser_clk_o     <= 1'b0;
            ser_data_o    <= 1'b0;
            ser_load_o    <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            sreg_q        <= sreg_d;
            cfg_rd_addr_o <= addr_d;
            overrun_o     <= ovr_d;
            busy_o        <= (state_d != IDLE);
            done_o        <= (state_d == DONE);
            ser_clk_o     <= (state_d == SHIFT_HI);
            ser_data_o    <= (state_d == SHIFT_LO || state_d == SHIFT_HI) ? sreg_d[CFG_W-1] : 1'b0;
            ser_load_o    <= (state_d == LOAD);
        end
    end

endmodule

// File: tb/tb_pad_cfg_loader.sv
// Randomized bench for pad_cfg_loader: captured serial stream and timing are
// compared against a chain model built directly from the pad memory contents.
module tb_pad_cfg_loader;

    localparam int NP = 8;
    localparam int CW = 13;
    localparam int CD = 2;
    localparam int AW = (NP > 1) ? $clog2(NP) : 1;
    localparam int EXP_BUSY = NP * (1 + 2 * CD * CW) + CD + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, abort = 1'b0;
    logic [AW-1:0] addr;
    logic [CW-1:0] rd_data;
    logic ser_clk, ser_data, ser_load, busy, done, overrun;
    logic [CW-1:0] mem [NP];

    logic s_start = 1'b0, s_abort = 1'b0;
    logic [0:0] s_addr, s_word = 1'b1;
    logic s_clk, s_data, s_load, s_busy, s_done, s_ovr;

    int errors = 0;
    int checks = 0;

    int c_busy, c_load, c_pulses, c_done, c_done_at, c_glitch;
    bit c_timeout;
    bit got_bits[$];
    bit exp_bits[$];

    always #5 clk = ~clk;

    assign rd_data = mem[addr];

    pad_cfg_loader #(.NUM_PADS(NP), .CFG_W(CW), .CLK_DIV(CD)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .cfg_rd_addr_o(addr), .cfg_rd_data_i(rd_data),
        .ser_clk_o(ser_clk), .ser_data_o(ser_data), .ser_load_o(ser_load),
        .busy_o(busy), .done_o(done), .overrun_o(overrun)
    );

    pad_cfg_loader #(.NUM_PADS(1), .CFG_W(1), .CLK_DIV(1)) u_small (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .abort_i(s_abort),
        .cfg_rd_addr_o(s_addr), .cfg_rd_data_i(s_word),
        .ser_clk_o(s_clk), .ser_data_o(s_data), .ser_load_o(s_load),
        .busy_o(s_busy), .done_o(s_done), .overrun_o(s_ovr)
    );

    // Chain model: pads high to low, each word MSB first.
    function automatic void build_expected();
        exp_bits.delete();
        for (int p = NP - 1; p >= 0; p--)
            for (int b = CW - 1; b >= 0; b--)
                exp_bits.push_back(mem[p][b]);
    endfunction

    function automatic int bit_mismatches();
        int n;
        n = 0;
        if (got_bits.size() != exp_bits.size()) return -1;
        foreach (exp_bits[i]) if (got_bits[i] !== exp_bits[i]) n++;
        return n;
    endfunction

    // Observe one load from the current negedge until busy falls.
    task automatic collect(input int bound);
        bit pc, pd, pl;
        c_busy = 0; c_load = 0; c_pulses = 0; c_done = 0; c_done_at = -1; c_glitch = 0;
        c_timeout = 1'b1; got_bits.delete();
        pc = 1'b0; pd = 1'b0; pl = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (busy) begin
                c_busy++;
                if (done) begin c_done++; c_done_at = c_busy; end
            end else if (c_busy > 0) begin
                c_timeout = 1'b0;
                break;
            end
            if (ser_load) c_load++;
            if (ser_load && !pl) c_pulses++;
            if (ser_clk && !pc) got_bits.push_back(ser_data);
            if (ser_clk && pc && ser_data !== pd) c_glitch++;
            if (!busy && (ser_clk || ser_data || ser_load || done)) c_glitch++;
            if (ser_load && (ser_clk || ser_data)) c_glitch++;
            pc = ser_clk; pd = ser_data; pl = ser_load;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, overrun, ser_clk, ser_data, ser_load, addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero", {busy, done, overrun, ser_clk, ser_data, ser_load, addr});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_autostart: busy=%b s_busy=%b expected 0", busy, s_busy);
        end
    endtask

    task automatic test_default_pattern();
        for (int k = 0; k < NP; k++) mem[k] = CW'(13'h1000 | k);
        build_expected();
        start = 1'b1; @(negedge clk); start = 1'b0;
        collect(1000);
        checks++;
        if (c_timeout) begin errors++; $display("FAIL default_timeout: load did not finish"); end
        checks++;
        if (c_busy !== 427) begin errors++; $display("FAIL default_busy: got %0d expected 427", c_busy); end
        checks++;
        if (got_bits.size() !== 104) begin errors++; $display("FAIL default_edges: got %0d expected 104", got_bits.size()); end
        checks++;
        if (bit_mismatches() !== 0) begin errors++; $display("FAIL default_bits: got %0d mismatches expected 0", bit_mismatches()); end
        checks++;
        if (c_pulses !== 1 || c_load !== CD) begin
            errors++; $display("FAIL default_load: got pulses=%0d cycles=%0d expected 1/%0d", c_pulses, c_load, CD);
        end
        checks++;
        if (c_done !== 1 || c_done_at !== 427) begin
            errors++; $display("FAIL default_done: got count=%0d at=%0d expected 1 at 427", c_done, c_done_at);
        end
        checks++;
        if (c_glitch !== 0) begin errors++; $display("FAIL default_serial_rules: got %0d violations expected 0", c_glitch); end
    endtask

    task automatic test_random_loads();
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < NP; k++) mem[k] = CW'($urandom);
            build_expected();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
            collect(1000);
            checks++;
            if (c_timeout || c_busy !== EXP_BUSY) begin
                errors++; $display("FAIL random_busy[%0d]: got %0d expected %0d", n, c_busy, EXP_BUSY);
            end
            checks++;
            if (bit_mismatches() !== 0) begin errors++; $display("FAIL random_bits[%0d]: got %0d mismatches expected 0", n, bit_mismatches()); end
            checks++;
            if (c_done !== 1 || c_pulses !== 1 || c_glitch !== 0) begin
                errors++; $display("FAIL random_ctrl[%0d]: got done=%0d load=%0d viol=%0d expected 1/1/0", n, c_done, c_pulses, c_glitch);
            end
        end
    endtask

    task automatic test_small_chain();
        logic [4:0] tab [6];
        for (int w = 1; w >= 0; w--) begin
            s_word = 1'(w);
            // {busy, ser_clk, ser_data, ser_load, done} per cycle from start
            tab[0] = 5'b10000;
            tab[1] = {3'b100, 1'(w), 1'b0} << 1;
            tab[1] = {1'b1, 1'b0, 1'(w), 2'b00};
            tab[2] = {1'b1, 1'b1, 1'(w), 2'b00};
            tab[3] = 5'b10010;
            tab[4] = 5'b10001;
            tab[5] = 5'b00000;
            s_start = 1'b1; @(negedge clk); s_start = 1'b0;
            for (int c = 0; c < 6; c++) begin
                checks++;
                if ({s_busy, s_clk, s_data, s_load, s_done} !== tab[c]) begin
                    errors++;
                    $display("FAIL small_seq w=%0d c=%0d: got %b expected %b", w, c, {s_busy, s_clk, s_data, s_load, s_done}, tab[c]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_abort();
        bit found;
        int bad;
        for (int k = 0; k < NP; k++) mem[k] = CW'($urandom);
        found = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (addr == AW'(3) && ser_clk) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort_reach_pad3: pad 3 shift-high not seen"); end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || ser_load || done || ser_clk || ser_data) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
        build_expected();
        start = 1'b1; @(negedge clk); start = 1'b0;
        collect(1000);
        checks++;
        if (c_busy !== EXP_BUSY || c_done !== 1 || bit_mismatches() !== 0) begin
            errors++; $display("FAIL abort_reload: got busy=%0d done=%0d mism=%0d expected %0d/1/0", c_busy, c_done, bit_mismatches(), EXP_BUSY);
        end
    endtask

    task automatic test_overrun();
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (49) @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_initial: got %b expected 0", overrun); end
        start = 1'b1; @(negedge clk); start = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        collect(1000);
        checks++;
        if (c_done !== 1 || overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_held: got done=%0d overrun=%b expected 1/1", c_done, overrun);
        end
    endtask

    task automatic test_start_abort_idle();
        int act;
        act = 0;
        start = 1'b1; abort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy || ser_clk || ser_load || done) act++;
        end
        start = 1'b0; abort = 1'b0;
        checks++;
        if (act !== 0 || overrun !== 1'b1) begin
            errors++; $display("FAIL start_abort_idle: got active=%0d overrun=%b expected 0/1", act, overrun);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NP; k++) mem[k] = CW'($urandom);
        build_expected();
        start = 1'b1; @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_clear: got %b expected 0", overrun); end
        collect(1000);
        checks++;
        if (c_busy !== EXP_BUSY || c_done !== 1 || bit_mismatches() !== 0) begin
            errors++; $display("FAIL b2b_first: got busy=%0d done=%0d mism=%0d expected %0d/1/0", c_busy, c_done, bit_mismatches(), EXP_BUSY);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_one_idle: got busy=%b expected 1", busy); end
        collect(1000);
        checks++;
        if (c_busy !== EXP_BUSY || c_done !== 1 || bit_mismatches() !== 0) begin
            errors++; $display("FAIL b2b_second: got busy=%0d done=%0d mism=%0d expected %0d/1/0", c_busy, c_done, bit_mismatches(), EXP_BUSY);
        end
    endtask

    task automatic test_reset_in_load();
        bit found;
        found = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (ser_load) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_reach_load: ser_load not seen"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, overrun, ser_clk, ser_data, ser_load, addr} !== '0) begin
            errors++; $display("FAIL rst_in_load: got %b expected all zero", {busy, done, overrun, ser_clk, ser_data, ser_load, addr});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ser_load !== 1'b0) begin
            errors++; $display("FAIL rst_release_idle: got busy=%b load=%b expected 0/0", busy, ser_load);
        end
    endtask

    initial begin
        for (int k = 0; k < NP; k++) mem[k] = '0;
        test_reset();
        test_default_pattern();
        test_random_loads();
        test_small_chain();
        test_abort();
        test_overrun();
        test_start_abort_idle();
        test_back_to_back();
        test_reset_in_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pad_cfg_loader.md
PAD_CFG_LOADER -- requirements
Module: pad_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_PADS, default 8: number of GPIO pads in the serial config chain (>=1).
REQ-002 SHALL have parameter CFG_W, default 13: config bits per pad (>=1).
REQ-003 SHALL have parameter CLK_DIV, default 2: clk_i cycles per serial-clock half period (>=1).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named as the codebase does.
REQ-005 SHALL have port clk_i, input, 1: sole clock, all state rising-edge.
REQ-006 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start_i, input, 1: level-sampled request to load the whole chain.
REQ-008 SHALL have port abort_i, input, 1: synchronous cancel of a load in progress.
REQ-009 SHALL have port cfg_rd_addr_o, output, AW = max(1, clog2(NUM_PADS)): pad index of the word being fetched.
REQ-010 SHALL have port cfg_rd_data_i, input, CFG_W: config word for cfg_rd_addr_o, valid in the same cycle.
REQ-011 SHALL have port ser_clk_o, output, 1: serial shift clock to the pad chain.
REQ-012 SHALL have port ser_data_o, output, 1: serial data, stable while ser_clk_o is high.
REQ-013 SHALL have port ser_load_o, output, 1: transfer strobe from the chain shift registers to the pad config latches.
REQ-014 SHALL have port busy_o, output, 1: high in every non-IDLE state.
REQ-015 SHALL have port done_o, output, 1: one-cycle pulse on successful completion.
REQ-016 SHALL have port overrun_o, output, 1: sticky flag, start_i seen while busy.

Function
REQ-017 SHALL use states IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE; all outputs registered.
REQ-018 IDLE: start_i=1 and abort_i=0 -> FETCH; cfg_rd_addr_o <= NUM_PADS-1; overrun_o <= 0.
REQ-019 FETCH (1 cycle): capture cfg_rd_data_i into shift reg -> SHIFT_LO with bit counter = CFG_W-1.
REQ-020 SHIFT_LO (CLK_DIV cycles): ser_clk_o=0, ser_data_o = shift-reg MSB; then -> SHIFT_HI.
REQ-021 SHIFT_HI (CLK_DIV cycles): ser_clk_o=1, ser_data_o unchanged; on exit, shift reg shifts left 1.
REQ-022 SHIFT_HI exit routing: bits remain -> SHIFT_LO; else pads remain -> FETCH with cfg_rd_addr_o decremented; else -> LOAD.
REQ-023 Word bit order: MSB first. Pad order: NUM_PADS-1 down to 0, so pad 0's word is shifted last.
REQ-024 LOAD (CLK_DIV cycles): ser_load_o=1, ser_clk_o=0, ser_data_o=0; then -> DONE.
REQ-025 DONE (1 cycle): done_o=1, then -> IDLE.
REQ-026 Outside SHIFT_LO/SHIFT_HI: ser_data_o=0 and ser_clk_o=0.
REQ-027 Total busy cycles per load: NUM_PADS*(1+2*CLK_DIV*CFG_W)+CLK_DIV+1 (427 at defaults).
REQ-028 start_i in any non-IDLE state: ignored; overrun_o <= 1.
REQ-029 abort_i in any non-IDLE state other than DONE: next state IDLE; all serial outputs 0; done_o and ser_load_o never asserted for that load.
REQ-030 abort_i in DONE: no effect, done_o still pulses.
REQ-031 start_i and abort_i both high in IDLE: abort wins, no load starts, overrun_o unchanged.
REQ-032 start_i held high through DONE: new load accepted in the first IDLE cycle after DONE.
REQ-033 Counters SHALL be sized for NUM_PADS=1 and CFG_W=1 without zero-width vectors.

Reset
REQ-034 rst_ni low SHALL immediately force state IDLE and all outputs to 0 (ser_*, busy_o, done_o, overrun_o, cfg_rd_addr_o), with all counters cleared.
REQ-035 Reset mid-load SHALL produce no ser_load_o pulse; chain contents after reset are undefined to the pads.
REQ-036 After rst_ni deasserts, the first load SHALL begin only on a sampled start_i.

Verification
REQ-037 Defaults, pad k word = 13'h1000|k, pulse start_i -> 104 ser_clk_o rising edges; data sequence is pad 7..0 MSB-first; 1 ser_load_o pulse of 2 cycles; done_o exactly 427 cycles after start.
REQ-038 NUM_PADS=1, CFG_W=1, CLK_DIV=1, word=1 -> busy_o for 5 cycles; ser_data_o=1 during a single ser_clk_o high; then load, then done.
REQ-039 abort_i during pad 3 SHIFT_HI -> busy_o=0 next cycle; no ser_load_o; no done_o; new start_i runs a complete load.
REQ-040 start_i pulsed at cycle 50 of a load -> overrun_o=1 held through DONE; cleared when the next start is accepted.
REQ-041 rst_ni low during LOAD -> ser_load_o=0 asynchronously (before the next clk_i edge); all outputs 0.
REQ-042 start_i=abort_i=1 in IDLE -> no activity; start_i held high across DONE -> back-to-back loads with one IDLE cycle between them.
